// File: rtl/cdr_period_tracker.sv
// -----------------------------------------------------------------------------
// cdr_period_tracker
// Receive-side clock-recovery period tracker. Holds the symbol sampling period
// (in i_clk cycles), nudges it up or down from filtered early/late decisions,
// clamps it to [PMIN, PMAX], emits a one-cycle sample strobe once per active
// period and flags lock once decisions stop moving the period.
//
// Ports
//   i_clk    : system clock, all state on the rising edge
//   i_rst    : asynchronous active-high reset (released synchronously upstream)
//   i_en     : tracking enable; 0 freezes vote/period, strobe keeps running
//   i_upd    : one-cycle decision tick
//   i_T      : transition seen in the current window (qualifies i_upd)
//   i_E      : direction, 1 = lengthen period, 0 = shorten period
//   o_nb_P   : tracked period in cycles
//   o_sample : one-cycle sample strobe, once per active period
//   o_at_min : o_nb_P == PMIN
//   o_at_max : o_nb_P == PMAX
//   o_lock   : LOCK_N consecutive qualified decisions without a period step
// -----------------------------------------------------------------------------
module cdr_period_tracker #(
  parameter int W      = 6,
  parameter int NOM    = 25,
  parameter int PMIN   = 23,
  parameter int PMAX   = 27,
  parameter int STEP   = 2,
  parameter int VOTE   = 1,
  parameter int LOCK_N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_upd,
  input  logic         i_T,
  input  logic         i_E,
  output logic [W-1:0] o_nb_P,
  output logic         o_sample,
  output logic         o_at_min,
  output logic         o_at_max,
  output logic         o_lock
);

  // Reject parameter sets that would make the clamp or counters meaningless.
  if (!((PMIN >= 2) && (PMIN <= NOM) && (NOM <= PMAX) && (PMAX < (1 << W)) &&
        (STEP >= 1) && (STEP < (1 << W)) && (VOTE >= 1) && (VOTE <= 7) &&
        (LOCK_N >= 1) && (LOCK_N <= 255))) begin : g_param_err
    $error("cdr_period_tracker: illegal parameter set");
  end

  localparam logic [W-1:0]      NOM_V  = W'(NOM);
  localparam logic [W-1:0]      PMIN_V = W'(PMIN);
  localparam logic [W-1:0]      PMAX_V = W'(PMAX);
  localparam logic [W-1:0]      ONE_V  = W'(1);
  // Step arithmetic is done one bit wider so neither direction can wrap.
  localparam logic [W:0]        STEP_X = (W+1)'(STEP);
  localparam logic [W:0]        PMIN_X = (W+1)'(PMIN);
  localparam logic [W:0]        PMAX_X = (W+1)'(PMAX);
  localparam logic signed [3:0] VOTE_P = 4'(VOTE);
  localparam logic signed [3:0] VOTE_N = -VOTE_P;
  localparam logic [7:0]        LOCK_P = 8'(LOCK_N);

  logic signed [3:0] r_vote;
  logic signed [3:0] w_vote_sum;
  logic signed [3:0] w_vote_nxt;
  logic              w_dec;
  logic              w_up_req;
  logic              w_dn_req;
  logic              w_step;
  logic [W:0]        w_sum_up;
  logic [W-1:0]      w_up_val;
  logic [W-1:0]      w_dn_val;
  logic [W-1:0]      w_p_nxt;
  logic [7:0]        r_lock_cnt;
  logic [7:0]        w_lock_cnt_nxt;
  logic [W-1:0]      r_cnt;
  logic [W-1:0]      r_pact;

  assign w_dec      = i_en & i_upd & i_T;
  assign w_vote_sum = r_vote + (i_E ? 4'sd1 : -4'sd1);
  assign w_up_req   = w_dec & (w_vote_sum == VOTE_P);
  assign w_dn_req   = w_dec & (w_vote_sum == VOTE_N);
  assign w_sum_up   = {1'b0, o_nb_P} + STEP_X;
  assign w_up_val   = (w_sum_up > PMAX_X) ? PMAX_V : w_sum_up[W-1:0];
  assign w_dn_val   = ({1'b0, o_nb_P} < (PMIN_X + STEP_X)) ? PMIN_V
                                                           : (o_nb_P - STEP_X[W-1:0]);

  // Next period / vote / lock-count selection from the qualified decision.
  always_comb begin
    w_p_nxt        = o_nb_P;
    w_vote_nxt     = r_vote;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_up_req) begin
      w_p_nxt = w_up_val;
    end else if (w_dn_req) begin
      w_p_nxt = w_dn_val;
    end else begin
      w_p_nxt = o_nb_P;
    end
    if (w_dec) begin
      // Reaching either vote threshold clears the vote, even when clamped.
      if (w_up_req || w_dn_req) begin
        w_vote_nxt = 4'sd0;
      end else begin
        w_vote_nxt = w_vote_sum;
      end
    end else begin
      w_vote_nxt = r_vote;
    end
    if (!w_dec) begin
      w_lock_cnt_nxt = r_lock_cnt;
    end else if (w_step) begin
      w_lock_cnt_nxt = 8'd0;
    end else if (r_lock_cnt == LOCK_P) begin
      w_lock_cnt_nxt = r_lock_cnt;
    end else begin
      w_lock_cnt_nxt = r_lock_cnt + 8'd1;
    end
  end

  // A clamped request leaves the value unchanged and so is not a step.
  assign w_step = (w_p_nxt != o_nb_P);

  // Period, vote filter, bound flags and lock detector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_nb_P     <= NOM_V;
      r_vote     <= 4'sd0;
      o_at_min   <= (NOM_V == PMIN_V);
      o_at_max   <= (NOM_V == PMAX_V);
      r_lock_cnt <= 8'd0;
      o_lock     <= 1'b0;
    end else begin
      o_nb_P     <= w_p_nxt;
      r_vote     <= w_vote_nxt;
      o_at_min   <= (w_p_nxt == PMIN_V);
      o_at_max   <= (w_p_nxt == PMAX_V);
      r_lock_cnt <= w_lock_cnt_nxt;
      o_lock     <= (w_lock_cnt_nxt == LOCK_P);
    end
  end

  // Sample strobe; the active period is only reloaded at wrap so a strobe
  // interval is never a mix of old and new period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= {W{1'b0}};
      r_pact   <= NOM_V;
      o_sample <= 1'b0;
    end else if (r_cnt == (r_pact - ONE_V)) begin
      r_cnt    <= {W{1'b0}};
      r_pact   <= o_nb_P;
      o_sample <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + ONE_V;
      o_sample <= 1'b0;
    end
  end

endmodule
